// File: rtl/msg_arb_pkg.sv
// Shared types and defaults for the message register arbiter.
package msg_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    localparam int MSG_W_DEF = 8;
    localparam int NREQ_MAX  = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req at or after ptr, cyclically upward.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          any,
    output logic [PW-1:0] idx
);

    // Scan N positions starting at ptr; the first active requester wins.
    always_comb begin
        int unsigned c;
        c   = 0;
        any = 1'b0;
        idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            c = (32'(ptr) + k) % 32'(N);
            if (!any && req[c]) begin
                any = 1'b1;
                idx = PW'(c);
            end
        end
    end

endmodule

// File: rtl/msg_reg_arbiter.sv
// Round-robin arbiter sharing one message holding register among NREQ producers,
// presented to a single consumer with a valid/ready handshake.
// Optional feature: define MSG_ARB_TIMEOUT_EN to discard a message the consumer
// has not taken within TIMEOUT_CYC cycles (pulses msg_drop).
import msg_arb_pkg::*;

module msg_reg_arbiter #(
    parameter int NREQ        = 4,
    parameter int MSG_W       = MSG_W_DEF,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*MSG_W-1:0]   msg_in,
    output logic [NREQ-1:0]         ack,
    output logic [MSG_W-1:0]        msg_data,
    output logic                    msg_valid,
    output logic [$clog2(NREQ)-1:0] msg_src,
    input  logic                    msg_ready,
    output logic                    msg_drop,
    output logic                    busy
);

    localparam int SW = $clog2(NREQ);

    // Reject out-of-range configurations at elaboration.
    if (NREQ < 2 || NREQ > NREQ_MAX || TIMEOUT_CYC < 2) begin : g_bad_params
        $error("msg_reg_arbiter: unsupported NREQ/TIMEOUT_CYC");
    end

    state_t          state, state_nxt;
    logic [SW-1:0]   rr_ptr;
    logic [SW-1:0]   src_inc;
    logic [SW-1:0]   pick_ptr;
    logic [SW-1:0]   pick_idx;
    logic            pick_any;
    logic            accept;
    logic            expire;
    logic            release_msg;
    logic            capture;

    assign accept      = (state == VALID) && msg_ready;
    assign release_msg = accept || expire;
    assign src_inc     = (msg_src == SW'(NREQ - 1)) ? '0 : msg_src + SW'(1);
    // On the release edge the search already uses the advanced pointer,
    // so back-to-back captures stay fair without an idle bubble.
    assign pick_ptr    = release_msg ? src_inc : rr_ptr;

    rr_pick #(
        .N  (NREQ),
        .PW (SW)
    ) u_pick (
        .req (req),
        .ptr (pick_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

`ifdef MSG_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] wait_cnt;

    assign expire = (state == VALID) && !msg_ready &&
                    (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Count consecutive unaccepted VALID cycles since the last capture.
    always_ff @(posedge clk) begin
        if (reset || capture) begin
            wait_cnt <= '0;
        end else if ((state == VALID) && !msg_ready) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    assign expire = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and capture decision.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    capture   = 1'b1;
                    state_nxt = VALID;
                end
            end
            VALID: begin
                if (accept) begin
                    if (pick_any) begin
                        capture = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (expire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State-derived outputs.
    always_comb begin
        msg_valid = (state == VALID);
        busy      = (state == VALID);
        msg_drop  = expire;
    end

    // Message register, source index, ack pulse and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            msg_data <= '0;
            msg_src  <= '0;
            ack      <= '0;
            rr_ptr   <= '0;
        end else begin
            ack <= '0;
            if (capture) begin
                msg_data <= msg_in[pick_idx*MSG_W +: MSG_W];
                msg_src  <= pick_idx;
                ack      <= NREQ'(1) << pick_idx;
            end
            if (release_msg) begin
                rr_ptr <= src_inc;
            end
        end
    end

endmodule
